// File: rtl/param_core.sv
// param_core: parametrised multi-cycle processor core with a shared req/ack memory port
module param_core #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24,
  parameter int NUM_REGS = 32,
  parameter int JUMP_SHIFT = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              retire
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_HALT = 3'd4;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_ADDI = 5'd2, OP_SHLLI = 5'd3, OP_SHRLI = 5'd4,
                         OP_JUMP = 5'd5, OP_JUMPLI = 5'd6, OP_JUMPL = 5'd7, OP_JUMPG = 5'd8, OP_JUMPE = 5'd9,
                         OP_JUMPNE = 5'd10, OP_CMP = 5'd11, OP_RET = 5'd12, OP_LOAD = 5'd13, OP_LOADI = 5'd14,
                         OP_STORE = 5'd15, OP_MOV = 5'd16;
  localparam int TW = 11 + JUMP_SHIFT;
  localparam int MSB = DATA_W - 1;
  logic [2:0]        r_state;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_pc, r_reta, r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req, r_we, r_sf, r_zf, r_of;
  logic [DATA_W-1:0] r_rf [32];
  logic [4:0]        w_op, w_rd, w_rs;
  logic [DATA_W-1:0] w_a, w_b, w_imm, w_d, w_res;
  logic [TW-1:0]     w_tgt_full;
  logic [ADDR_W-1:0] w_tgt, w_npc;
  logic              w_wr, w_take, w_ack;
  assign w_op = r_ir[15:11];
  assign w_rd = 5'({1'b0, r_ir[4:0]} % 6'(NUM_REGS));
  assign w_rs = 5'({1'b0, r_ir[9:5]} % 6'(NUM_REGS));
  assign w_a = r_rf[w_rd];
  assign w_b = r_rf[w_rs];
  assign w_imm = DATA_W'(r_ir[10:5]);
  assign w_d = w_a - w_b;
  assign w_tgt_full = TW'(r_ir[10:0]) << JUMP_SHIFT;
  assign w_tgt = ADDR_W'(w_tgt_full);
  assign w_ack = r_req & mem_ack;
  assign mem_req = r_req;
  assign mem_we = r_we;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign halted = r_state == S_HALT;
  assign retire = (r_state == S_EXEC) | ((r_state == S_MEM) & w_ack);
  // ALU result, write enable, branch decision and next PC for the EXECUTE step
  always_comb begin
    w_res = w_op == OP_ADD ? w_a + w_b :
            w_op == OP_SUB ? w_d :
            w_op == OP_ADDI ? w_a + w_imm :
            w_op == OP_SHLLI ? w_a << w_imm :
            w_op == OP_SHRLI ? w_a >> w_imm :
            w_op == OP_LOADI ? w_imm : w_b;
    w_wr = w_op inside {OP_ADD, OP_SUB, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOADI, OP_MOV};
    w_take = (w_op == OP_JUMP) | (w_op == OP_JUMPLI) |
             ((w_op == OP_JUMPL) & (r_sf ^ r_of)) |
             ((w_op == OP_JUMPG) & ~(r_sf ^ r_of) & ~r_zf) |
             ((w_op == OP_JUMPE) & r_zf) |
             ((w_op == OP_JUMPNE) & ~r_zf);
    w_npc = w_take ? w_tgt : w_op == OP_RET ? r_reta : r_pc;
  end
  // FSM: a request is raised one cycle after entering FETCH/MEM unless already held over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ir <= '0;
      r_pc <= RESET_PC;
      r_reta <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_sf <= 1'b0;
      r_zf <= 1'b0;
      r_of <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:
          if (!r_req) begin
            r_req <= 1'b1;
            r_addr <= r_pc;
          end else if (mem_ack) begin
            r_ir <= mem_rdata[15:0];
            r_pc <= r_pc + ADDR_W'(1);
            r_req <= 1'b0;
            r_state <= S_DECODE;
          end
        S_DECODE:
          r_state <= (w_op == OP_LOAD || w_op == OP_STORE) ? S_MEM : (w_op > OP_MOV) ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (w_wr) r_rf[w_rd] <= w_res;
          if (w_op == OP_CMP) begin
            r_sf <= w_d[MSB];
            r_zf <= w_d == '0;
            r_of <= (w_a[MSB] != w_b[MSB]) & (w_d[MSB] != w_a[MSB]);
          end
          if (w_op == OP_JUMPLI) r_reta <= r_pc;
          r_pc <= w_npc;
          r_addr <= w_npc;
          r_req <= 1'b1;
          r_state <= S_FETCH;
        end
        S_MEM:
          if (!r_req) begin
            r_req <= 1'b1;
            r_we <= w_op == OP_STORE;
            r_addr <= ADDR_W'(w_op == OP_STORE ? w_a : w_b);
            r_wdata <= w_b;
          end else if (mem_ack) begin
            if (!r_we) r_rf[w_rd] <= mem_rdata;
            r_we <= 1'b0;
            r_addr <= r_pc;
            r_state <= S_FETCH;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_param_core.sv
// tb_param_core: directed programs with a bus-transaction scoreboard for param_core
module tb_param_core;
  localparam logic [4:0] op_add = 0, op_sub = 1, op_addi = 2, op_shlli = 3, op_shrli = 4, op_jump = 5,
                         op_jumpli = 6, op_jumpl = 7, op_jumpg = 8, op_jumpe = 9, op_jumpne = 10,
                         op_cmp = 11, op_ret = 12, op_load = 13, op_loadi = 14, op_store = 15, op_mov = 16;
  typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} tx_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst2_n = 1'b0, ld = 1'b0;
  logic req1, we1, ack1, halt1, ret1, req2, we2, ack2, halt2, ret2;
  logic [23:0] addr1, wd1, rd1;
  logic [15:0] addr2;
  logic [31:0] wd2, rd2;
  logic [23:0] m1 [1024], p1 [1024];
  logic [31:0] m2 [1024], p2 [1024];
  int n_vec = 0, n_err = 0, cyc = 0, cnt1 = 0;
  int rt[$];
  tx_t q1[$], q2[$];
  always #5 clk = ~clk;
  param_core dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(rd1), .mem_ack(ack1), .halted(halt1), .retire(ret1));
  param_core #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(8), .JUMP_SHIFT(4), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2),
    .mem_rdata(rd2), .mem_ack(ack2), .halted(halt2), .retire(ret2));
  // data region at 0x200 and above answers after 3 wait states; code region is zero-wait
  assign ack1 = req1 && (cnt1 >= ((addr1 >= 24'h200) ? 3 : 0));
  assign ack2 = req2;
  assign rd1 = m1[addr1[9:0]];
  assign rd2 = m2[addr2[9:0]];
  // memory models: bulk program load, otherwise commit acknowledged writes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    cnt1 <= (req1 && !ack1) ? cnt1 + 1 : 0;
    if (ld) begin
      for (int i = 0; i < 1024; i++) begin
        m1[i] <= p1[i];
        m2[i] <= p2[i];
      end
    end else begin
      if (req1 && ack1 && we1) m1[addr1[9:0]] <= wd1;
      if (req2 && ack2 && we2) m2[addr2[9:0]] <= wd2;
    end
  end
  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rd);
    return {op, 1'b0, rs, rd};
  endfunction
  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [5:0] imm, input logic [4:0] rd);
    return {op, imm, rd};
  endfunction
  function automatic logic [15:0] enc_l(input logic [4:0] op, input logic [10:0] imm);
    return {op, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ex(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (k == 1) q1.push_back('{we, a, d});
    else q2.push_back('{we, a, d});
  endtask
  // every request cycle must match the queue head; an ack retires it
  task automatic chk_bus(input int k, input logic we, input logic [31:0] a, input logic [31:0] d, input logic ack);
    tx_t h, o;
    o = '{we, a, we ? d : 32'd0};
    if (k == 1 && q1.size() > 0) h = q1[0];
    else if (k == 2 && q2.size() > 0) h = q2[0];
    else h = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    h.d = h.we ? h.d : 32'd0;
    n_vec++;
    assert (o === h) else begin
      n_err++;
      $error("FAIL bus%0d observed we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", k, o.we, o.a, o.d, h.we, h.a, h.d);
    end
    if (ack && k == 1 && q1.size() > 0) void'(q1.pop_front());
    if (ack && k == 2 && q2.size() > 0) void'(q2.pop_front());
  endtask
  // bus monitor and retire timestamps, sampled away from the active edge
  always @(negedge clk) begin
    if (ret1) rt.push_back(cyc);
    if (req1) chk_bus(1, we1, 32'(addr1), 32'(wd1), ack1);
    if (req2) chk_bus(2, we2, 32'(addr2), wd2, ack2);
  end
  initial begin
    for (int i = 0; i < 1024; i++) begin
      p1[i] = '0;
      p2[i] = '0;
    end
    p1[0] = 24'(enc_i(op_loadi, 5, 1));
    p1[1] = 24'(enc_i(op_loadi, 7, 2));
    p1[2] = 24'(enc_r(op_add, 2, 1));
    p1[3] = 24'(enc_i(op_loadi, 3, 3));
    p1[4] = 24'(enc_i(op_shlli, 8, 3));
    p1[5] = 24'(enc_r(op_store, 1, 3));
    p1[6] = 24'(enc_i(op_loadi, 0, 1));
    p1[7] = 24'(enc_i(op_loadi, 1, 2));
    p1[8] = 24'(enc_r(op_sub, 2, 1));
    p1[9] = 24'(enc_r(op_store, 1, 3));
    p1[10] = 24'(enc_r(op_cmp, 2, 1));
    p1[11] = 24'(enc_l(op_jumpl, 2));
    p1[32] = 24'(enc_i(op_loadi, 42, 6));
    p1[33] = 24'(enc_i(op_shlli, 6, 6));
    p1[34] = 24'(enc_i(op_addi, 60, 6));
    p1[35] = 24'(enc_r(op_store, 6, 3));
    p1[36] = 24'(enc_r(op_load, 3, 5));
    p1[37] = 24'(enc_i(op_addi, 1, 3));
    p1[38] = 24'(enc_r(op_store, 5, 3));
    p1[39] = 24'(enc_r(op_mov, 5, 8));
    p1[40] = 24'(enc_r(op_cmp, 5, 8));
    p1[41] = 24'(enc_l(op_jumpne, 7));
    p1[42] = 24'(enc_l(op_jumpg, 7));
    p1[43] = 24'(enc_l(op_jumpe, 3));
    p1[48] = 24'(enc_i(op_shrli, 4, 8));
    p1[49] = 24'(enc_r(op_store, 8, 3));
    p1[50] = 24'(enc_l(op_jump, 4));
    p1[64] = 24'(enc_l(op_jumpli, 16));
    p1[65] = 24'h00F800;
    p1[256] = 24'(enc_l(op_ret, 0));
    p2[1023] = 32'(enc_i(op_loadi, 5, 9));
    p2[0] = 32'(enc_i(op_loadi, 60, 2));
    p2[1] = 32'(enc_r(op_store, 1, 2));
    p2[2] = 32'(enc_i(op_shlli, 40, 1));
    p2[3] = 32'(enc_r(op_store, 9, 2));
    p2[4] = 32'(enc_i(op_loadi, 1, 3));
    p2[5] = 32'(enc_i(op_shlli, 31, 3));
    p2[6] = 32'(enc_r(op_store, 3, 2));
    p2[7] = 32'h0000F800;
    ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    chk("rst_req", 32'(req1), 0);
    chk("rst_we", 32'(we1), 0);
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_wdata", 32'(wd1), 0);
    chk("rst_halted", 32'(halt1), 0);
    chk("rst_retire", 32'(ret1), 0);
    for (int a = 0; a < 6; a++) ex(1, 0, a, 0);
    ex(1, 1, 'h300, 12);
    for (int a = 6; a < 10; a++) ex(1, 0, a, 0);
    ex(1, 1, 'h300, 'hFFFFFF);
    for (int a = 10; a < 12; a++) ex(1, 0, a, 0);
    for (int a = 'h20; a < 'h24; a++) ex(1, 0, a, 0);
    ex(1, 1, 'h300, 'hABC);
    ex(1, 0, 'h24, 0);
    ex(1, 0, 'h300, 0);
    ex(1, 0, 'h25, 0);
    ex(1, 0, 'h26, 0);
    ex(1, 1, 'h301, 'hABC);
    for (int a = 'h27; a < 'h2C; a++) ex(1, 0, a, 0);
    ex(1, 0, 'h30, 0);
    ex(1, 0, 'h31, 0);
    ex(1, 1, 'h301, 'hAB);
    ex(1, 0, 'h32, 0);
    ex(1, 0, 'h40, 0);
    ex(1, 0, 'h100, 0);
    ex(1, 0, 'h41, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_before_first_edge", 32'(req1), 0);
    @(posedge clk);
    #1 chk("first_req", 32'(req1), 1);
    chk("first_addr", 32'(addr1), 0);
    for (int i = 0; i < 3000 && !halt1; i++) @(negedge clk);
    chk("halt_on_illegal", 32'(halt1), 1);
    chk("retire_count", rt.size(), 29);
    chk("q1_drained", q1.size(), 0);
    if (rt.size() > 16) begin
      chk("cyc_alu_1", rt[1] - rt[0], 3);
      chk("cyc_alu_2", rt[2] - rt[1], 3);
      chk("cyc_store_wait", rt[5] - rt[4], 7);
      chk("cyc_after_store", rt[6] - rt[5], 3);
      chk("cyc_store_abc", rt[15] - rt[14], 7);
      chk("cyc_load_abc", rt[16] - rt[15], 7);
    end
    repeat (5) begin
      @(negedge clk);
      chk("halt_no_req", 32'(req1), 0);
    end
    chk("halt_sticky", 32'(halt1), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) p1[i] = '0;
    p1[0] = 24'(enc_i(op_loadi, 63, 3));
    p1[1] = 24'(enc_i(op_shlli, 4, 3));
    p1[2] = 24'(enc_r(op_store, 3, 3));
    p1[3] = 24'h00F800;
    ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    chk("rst_clears_halt", 32'(halt1), 0);
    q1.delete();
    rt.delete();
    for (int a = 0; a < 3; a++) ex(1, 0, a, 0);
    ex(1, 1, 'h3F0, 'h3F0);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && !(req1 && we1); i++) @(negedge clk);
    chk("store_issued", 32'(req1 && we1), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_req", 32'(req1), 0);
    chk("async_we", 32'(we1), 0);
    chk("async_addr", 32'(addr1), 0);
    chk("async_wdata", 32'(wd1), 0);
    chk("async_retire", 32'(ret1), 0);
    chk("async_halted", 32'(halt1), 0);
    q1.delete();
    rt.delete();
    for (int a = 0; a < 3; a++) ex(1, 0, a, 0);
    ex(1, 1, 'h3F0, 'h3F0);
    ex(1, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 500 && !halt1; i++) @(negedge clk);
    chk("restart_halt", 32'(halt1), 1);
    chk("restart_q_drained", q1.size(), 0);
    chk("restart_retires", rt.size(), 3);
    ex(2, 0, 'hFFFF, 0);
    ex(2, 0, 0, 0);
    ex(2, 0, 1, 0);
    ex(2, 1, 60, 5);
    ex(2, 0, 2, 0);
    ex(2, 0, 3, 0);
    ex(2, 1, 60, 0);
    for (int a = 4; a < 7; a++) ex(2, 0, a, 0);
    ex(2, 1, 60, 'h8000_0000);
    ex(2, 0, 7, 0);
    chk("dut2_rst_addr", 32'(addr2), 0);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 500 && !halt2; i++) @(negedge clk);
    chk("dut2_halt", 32'(halt2), 1);
    chk("dut2_q_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/param_core.md
# param_core

Parametrised multi-cycle processor core: fetches 16-bit instructions and executes ALU, compare, branch, call/return, load and store operations against a single unified memory port. It uses a request/acknowledge handshake that tolerates any number of wait states. The core owns its register file, status flags, program counter and return link, and traps on illegal opcodes. It is the next-generation CPU core, generalised in data/address width, register count and jump scaling.

## Interface
- DATA_W, 24: register, ALU and memory data width; must be ≥ 16.
- ADDR_W, 24: memory address and PC width.
- NUM_REGS, 32: register count; must be ≤ 32; index is instr[4:0] or instr[9:5] modulo NUM_REGS.
- JUMP_SHIFT, 4: jump target = zext(instr[10:0]) << JUMP_SHIFT, truncated to ADDR_W.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data; instruction is mem_rdata[15:0]; valid in the mem_ack cycle.
- mem_ack  in  1  transaction complete; sampled only while mem_req = 1; may be high in the same cycle as mem_req.
- halted  out  1  trap state reached; sticky until reset.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- Instruction fields: op = [15:11], rs = [9:5], rd = [4:0], immS = zext([10:5]), immL = [10:0].
- Opcodes: ADD 0, SUB 1, ADDI 2, SHLLI 3, SHRLI 4, JUMP 5, JUMPLI 6, JUMPL 7, JUMPG 8, JUMPE 9, JUMPNE 10, CMP 11, RET 12, LOAD 13, LOADI 14, STORE 15, MOV 16. Opcodes 17–31 are illegal.
- ADD / SUB: rd ← rd ± rs, modulo 2^DATA_W. ADDI: rd ← rd + immS. LOADI: rd ← immS. MOV: rd ← rs.
- SHLLI / SHRLI: logical shift of rd by immS. A shift count ≥ DATA_W yields 0.
- CMP: d = rd − rs, DATA_W bits. SF ← d[MSB]; ZF ← (d == 0); OF ← (rd[MSB] ≠ rs[MSB]) & (d[MSB] ≠ rd[MSB]). Only CMP updates the flags.
- JUMP: PC ← target.
- JUMPLI: reta ← PC of the next instruction, then PC ← target.
- JUMPL taken if SF ≠ OF. JUMPG taken if SF == OF & !ZF. JUMPE taken if ZF. JUMPNE taken if !ZF. A not-taken branch falls through.
- RET: PC ← reta.
- LOAD: rd ← mem[rs]. STORE: mem[rd] ← rs. Address = register value truncated or zero-extended to ADDR_W.
- Illegal opcode: enter HALT. No register, flag or PC change. retire stays 0. halted = 1.
- States:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On mem_ack: latch the instruction, PC ← PC + 1 (wraps mod 2^ADDR_W), go to DECODE.
  - DECODE: latch rd/rs values. LOAD or STORE → MEM; illegal → HALT; otherwise → EXECUTE.
  - EXECUTE: write result, flags and PC; pulse retire; → FETCH.
  - MEM: hold the request until mem_ack. Load writes rd on ack. Pulse retire on ack; → FETCH.
  - HALT: absorbing; only reset exits.
- Registers are all writable, including register 0.

## Timing
- Reset (asynchronous, immediate): mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, halted = 0, retire = 0. PC = RESET_PC, reta = 0, all registers = 0, flags = 0, state = FETCH. A pending transaction is abandoned; an ack arriving during or after reset is ignored.
- Once mem_req is raised, mem_addr, mem_we and mem_wdata are held stable until the mem_ack cycle. mem_req drops in the cycle after ack unless the next state issues a new request.
- Zero-wait memory (ack in the same cycle as req): non-memory instruction = 3 cycles; LOAD / STORE = 4 cycles. Each wait cycle adds 1.
- First FETCH request is asserted in the first clk edge cycle after rst_n rises.
- Register writes are visible to the next instruction's DECODE; no hazards exist.
- JUMPLI with target equal to its own address loops forever; this is legal.

## Test plan
- Reset, zero-wait memory, program LOADI r1,5; LOADI r2,7; ADD r1,r2 → r1 = 12; retire pulses every 3 cycles.
- Wrap and flags: LOADI r1,0; LOADI r2,1; SUB r1,r2 → r1 = 0xFFFFFF. Then CMP r1,r2 → SF = 1, ZF = 0, OF = 0; a following JUMPL is taken to immL << 4.
- Memory with 3 wait states: STORE of 0xABC to the address held in rd, then LOAD back into r5 → r5 = 0xABC. Address and data stay stable through the waits; each instruction takes 7 cycles.
- JUMPLI 0x10 at PC 4 → PC = 0x100, reta = 5. RET at 0x100 → next fetch address = 5.
- Opcode 0x1F → halted = 1 and mem_req stays 0. Pulse rst_n low mid-MEM → all outputs at reset values immediately; fetch restarts at RESET_PC.
- DATA_W = 32, ADDR_W = 16, NUM_REGS = 8: SHLLI by 40 → 0; PC 0xFFFF increments to 0x0000.
